// File: rtl/can_bit_transmitter.sv
// -----------------------------------------------------------------------------
// can_bit_transmitter
// Transmit-side CAN bit engine. Accepts frame bits from the frame builder with a
// valid/ready handshake and drives each one onto the TX pin for CLKS_PER_BIT
// clocks. After STUFF_LIMIT equal bits inside a stuffed field it inserts one
// complementary stuff bit.
//
// Optional build macro: CAN_TX_BIT_ERR_CHECK_EN
//   When defined, the synchronised RX readback is compared with o_tx at clock
//   SAMPLE_PT of every bit. A mismatch pulses o_bit_err and aborts the frame.
//   When undefined, o_bit_err is tied low and i_rx_synched is ignored.
//
// Ports:
//   i_sys_clk     system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_bit         next frame bit (1 = recessive)
//   i_stuff_en    i_bit belongs to a stuffed field
//   i_last        i_bit is the last bit of the frame
//   i_bit_valid   i_bit / i_stuff_en / i_last valid
//   o_bit_ready   a bit is accepted this cycle if i_bit_valid is high
//   i_rx_synched  double-synchronised bus readback
//   o_tx          CAN TX pin, registered, idle recessive (1)
//   o_busy        frame in progress
//   o_stuff_bit   high for the whole period of a stuff bit
//   o_underrun    one-cycle pulse: no bit supplied at a mid-frame boundary
//   o_bit_err     one-cycle pulse: readback mismatch
// -----------------------------------------------------------------------------
module can_bit_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned SAMPLE_PT    = 70,
    parameter int unsigned STUFF_LIMIT  = 5
) (
    input  logic i_sys_clk,
    input  logic i_reset,
    input  logic i_bit,
    input  logic i_stuff_en,
    input  logic i_last,
    input  logic i_bit_valid,
    output logic o_bit_ready,
    input  logic i_rx_synched,
    output logic o_tx,
    output logic o_busy,
    output logic o_stuff_bit,
    output logic o_underrun,
    output logic o_bit_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned RUN_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUFF_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STUFF = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             stuff_bit_q, stuff_bit_d;
    logic             underrun_q, underrun_d;
    logic             bit_err_q, bit_err_d;
    logic             last_bit_q, last_bit_d;     // value of the last bit on the wire (stuff reference)
    logic             last_q, last_d;             // bit in flight (or the one that caused the stuff) ends the frame
    logic             stuff_pend_q, stuff_pend_d; // a stuff bit follows the current bit

    logic             transfer_c;
    logic             at_end_c;
    logic             err_c;
    logic [RUN_W-1:0] run_base_c;
    logic [RUN_W-1:0] run_new_c;

    assign transfer_c = i_bit_valid && ready_q;
    assign at_end_c   = (cnt_q == CNT_LAST);

`ifdef CAN_TX_BIT_ERR_CHECK_EN
    // Readback compare at the sample point of every data or stuff bit
    assign err_c = (state_q != ST_IDLE) && (cnt_q == CNT_W'(SAMPLE_PT)) && (i_rx_synched != tx_q);
`else
    localparam int unsigned unused_sample_pt = SAMPLE_PT;
    logic unused_rx;
    assign unused_rx = i_rx_synched;
    assign err_c     = 1'b0;
`endif

    // A new frame starts its run from zero; the stuff bit itself seeds the next run
    assign run_base_c = (state_q == ST_IDLE) ? '0 : run_q;
    assign run_new_c  = (i_bit == last_bit_q) ? (run_base_c + RUN_W'(1)) : RUN_W'(1);

    // State and output registers
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            run_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            stuff_bit_q  <= 1'b0;
            underrun_q   <= 1'b0;
            bit_err_q    <= 1'b0;
            last_bit_q   <= 1'b1;
            last_q       <= 1'b0;
            stuff_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            stuff_bit_q  <= stuff_bit_d;
            underrun_q   <= underrun_d;
            bit_err_q    <= bit_err_d;
            last_bit_q   <= last_bit_d;
            last_q       <= last_d;
            stuff_pend_q <= stuff_pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer_c) state_d = ST_SEND;
            end
            ST_SEND, ST_STUFF: begin
                if (err_c) begin
                    state_d = ST_IDLE;
                end else if (at_end_c) begin
                    // ready_q is low when a stuff is pending or the frame is done
                    if (stuff_pend_q)    state_d = ST_STUFF;
                    else if (transfer_c) state_d = ST_SEND;
                    else                 state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d        = cnt_q;
        run_d        = run_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        stuff_bit_d  = stuff_bit_q;
        underrun_d   = 1'b0;
        bit_err_d    = 1'b0;
        last_bit_d   = last_bit_q;
        last_d       = last_q;
        stuff_pend_d = stuff_pend_q;

        if (err_c) begin
            // Abort: release the bus and forget all stuffing history
            tx_d         = 1'b1;
            busy_d       = 1'b0;
            stuff_bit_d  = 1'b0;
            bit_err_d    = 1'b1;
            cnt_d        = '0;
            run_d        = '0;
            last_d       = 1'b0;
            stuff_pend_d = 1'b0;
        end else if (transfer_c) begin
            tx_d        = i_bit;
            cnt_d       = '0;
            busy_d      = 1'b1;
            stuff_bit_d = 1'b0;
            last_d      = i_last;
            if (i_stuff_en) begin
                run_d        = run_new_c;
                last_bit_d   = i_bit;
                stuff_pend_d = (run_new_c == RUN_LIMIT);
            end else begin
                run_d        = '0;
                stuff_pend_d = 1'b0;
            end
        end else if (state_q != ST_IDLE) begin
            if (!at_end_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (state_d == ST_STUFF) begin
                tx_d         = ~last_bit_q;
                cnt_d        = '0;
                stuff_bit_d  = 1'b1;
                run_d        = RUN_W'(1);
                last_bit_d   = ~last_bit_q;
                stuff_pend_d = 1'b0;
            end else begin
                // Frame end: either the last bit finished or the source ran dry
                tx_d         = 1'b1;
                busy_d       = 1'b0;
                stuff_bit_d  = 1'b0;
                cnt_d        = '0;
                underrun_d   = !last_q;
                last_d       = 1'b0;
                stuff_pend_d = 1'b0;
            end
        end

        // Ready is registered: raise it for the coming boundary cycle when a follow-on bit is wanted
        ready_d = (state_d == ST_IDLE) || ((cnt_d == CNT_LAST) && !last_d && !stuff_pend_d);
    end

    assign o_tx        = tx_q;
    assign o_busy      = busy_q;
    assign o_bit_ready = ready_q;
    assign o_stuff_bit = stuff_bit_q;
    assign o_underrun  = underrun_q;
    assign o_bit_err   = bit_err_q;

endmodule
